// File: rtl/ntt_ctrl.sv
// Address/strobe sequencer for an in-place radix-2 forward NTT over N = 2**LOGN coefficients.
// Walks LOGN stages of N/2 butterflies and drains the PIPE_LAT-deep datapath between stages.
module ntt_ctrl #(
  parameter int LOGN     = 8,
  parameter int PIPE_LAT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            rd_en,
  output logic [LOGN-1:0] rd_addr_a,
  output logic [LOGN-1:0] rd_addr_b,
  output logic [LOGN-1:0] tf_addr,
  output logic            wr_en,
  output logic [LOGN-1:0] wr_addr_a,
  output logic [LOGN-1:0] wr_addr_b,
  output logic [2:0]      stage
);

  localparam int N  = 1 << LOGN;
  localparam int CW = LOGN - 1;
  localparam int DW = $clog2(PIPE_LAT + 1);
  localparam int SW = $clog2(LOGN);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [DW-1:0]   drain_cnt;
  logic [2:0]      stage_q;
  logic            last_c, last_drain, last_stage;

  logic [LOGN-1:0] c_ext, len, grp, offs, a_now, b_now, tf_now;
  logic [SW-1:0]   kshift;
  logic [LOGN-1:0] ra_q, rb_q, tf_q;

  logic            vld_pipe [PIPE_LAT];
  logic [LOGN-1:0] pa_pipe  [PIPE_LAT];
  logic [LOGN-1:0] pb_pipe  [PIPE_LAT];

  assign last_c     = &cnt;
  assign last_drain = (drain_cnt == DW'(PIPE_LAT - 1));
  assign last_stage = (stage_q == 3'(LOGN - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    rd_en     = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = RUN;
      end
      RUN: begin
        rd_en = 1'b1;
        if (last_c) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (last_drain) state_nxt = last_stage ? DONE : RUN;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      drain_cnt <= '0;
      stage_q   <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          cnt     <= '0;
          stage_q <= '0;
        end
        RUN: begin
          if (!last_c) cnt <= cnt + CW'(1);
          drain_cnt <= '0;
        end
        DRAIN: begin
          drain_cnt <= drain_cnt + DW'(1);
          if (last_drain && !last_stage) begin
            stage_q <= stage_q + 3'd1;
            cnt     <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Butterfly c of stage s: insert a zero bit at position k = LOGN-1-s to get X, set it to get Y.
  always_comb begin
    c_ext  = {1'b0, cnt};
    kshift = SW'(LOGN - 1) - SW'(stage_q);
    len    = LOGN'(N >> 1) >> stage_q;
    grp    = c_ext >> kshift;
    offs   = c_ext & (len - LOGN'(1));
    a_now  = ((grp << kshift) << 1) | offs;
    b_now  = a_now | len;
    tf_now = (LOGN'(1) << stage_q) + grp;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ra_q <= '0;
      rb_q <= '0;
      tf_q <= '0;
    end else if (state == RUN) begin
      ra_q <= a_now;
      rb_q <= b_now;
      tf_q <= tf_now;
    end
  end

  assign rd_addr_a = (state == RUN) ? a_now  : ra_q;
  assign rd_addr_b = (state == RUN) ? b_now  : rb_q;
  assign tf_addr   = (state == RUN) ? tf_now : tf_q;
  assign stage     = stage_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < PIPE_LAT; i++) begin
        vld_pipe[i] <= 1'b0;
        pa_pipe[i]  <= '0;
        pb_pipe[i]  <= '0;
      end
    end else begin
      vld_pipe[0] <= rd_en;
      pa_pipe[0]  <= rd_addr_a;
      pb_pipe[0]  <= rd_addr_b;
      for (int i = 1; i < PIPE_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        pa_pipe[i]  <= pa_pipe[i-1];
        pb_pipe[i]  <= pb_pipe[i-1];
      end
    end
  end

  assign wr_en     = vld_pipe[PIPE_LAT-1];
  assign wr_addr_a = pa_pipe[PIPE_LAT-1];
  assign wr_addr_b = pb_pipe[PIPE_LAT-1];

endmodule

// File: tb/tb_ntt_ctrl.sv
// Randomized self-checking bench for ntt_ctrl against a per-cycle schedule built from the
// stage/group/offset arithmetic of the transform.
module tb_ntt_ctrl;
  localparam int LOGN = 8;
  localparam int PL   = 2;
  localparam int N    = 1 << LOGN;
  localparam int TOT  = 1 + LOGN * (N/2 + PL);

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start = 1'b0;
  logic            busy, done, rd_en, wr_en;
  logic [LOGN-1:0] rd_addr_a, rd_addr_b, tf_addr, wr_addr_a, wr_addr_b;
  logic [2:0]      stage;

  ntt_ctrl #(.LOGN(LOGN), .PIPE_LAT(PL)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tf_addr(tf_addr),
    .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b), .stage(stage)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int last_done_cyc = -1;
  int h_a = 0, h_b = 0, h_tf = 0;

  int e_rd [0:TOT+1];
  int e_a  [0:TOT+1];
  int e_b  [0:TOT+1];
  int e_tf [0:TOT+1];
  int e_st [0:TOT+1];
  int e_wr [0:TOT+1];
  int e_wa [0:TOT+1];
  int e_wb [0:TOT+1];

  always @(posedge clk) cyc++;
  always @(negedge clk) if (done === 1'b1) last_done_cyc = cyc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Schedule indexed by cycles since start was accepted (cycle 0).
  task automatic build_model();
    int t;
    t = 1;
    e_rd[0] = 0; e_a[0] = 0; e_b[0] = 0; e_tf[0] = 0; e_st[0] = 0;
    for (int s = 0; s < LOGN; s++) begin
      int len;
      len = N >> (s + 1);
      for (int c = 0; c < N/2; c++) begin
        e_rd[t] = 1;
        e_a[t]  = (c / len) * 2 * len + (c % len);
        e_b[t]  = e_a[t] + len;
        e_tf[t] = (1 << s) + c / len;
        e_st[t] = s;
        t++;
      end
      for (int d = 0; d < PL; d++) begin
        e_rd[t] = 0; e_a[t] = e_a[t-1]; e_b[t] = e_b[t-1]; e_tf[t] = e_tf[t-1];
        e_st[t] = s;
        t++;
      end
    end
    for (int k = t; k <= TOT + 1; k++) begin
      e_rd[k] = 0; e_a[k] = e_a[k-1]; e_b[k] = e_b[k-1]; e_tf[k] = e_tf[k-1];
      e_st[k] = LOGN - 1;
    end
    for (int k = 0; k <= TOT + 1; k++) begin
      e_wr[k] = (k >= PL) ? e_rd[k-PL] : 0;
      e_wa[k] = (k >= PL) ? e_a[k-PL]  : 0;
      e_wb[k] = (k >= PL) ? e_b[k-PL]  : 0;
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_rd_en", rd_en, 0);
    end
  endtask

  // One full transform; spur_a/spur_b are extra start pulses that must be ignored.
  task automatic run_full(input int spur_a, input int spur_b, output int start_abs);
    int nrd, nwr, ndone, dcyc;
    nrd = 0; nwr = 0; ndone = 0; dcyc = -1; start_abs = -1;
    for (int t = 0; t <= TOT + 1; t++) begin
      @(posedge clk); #1;
      start = (t == 0 || t == spur_a || t == spur_b);
      @(negedge clk);
      if (t == 0) start_abs = cyc;
      chk("busy", busy, (t >= 1 && t <= TOT));
      chk("done", done, (t == TOT));
      chk("rd_en", rd_en, e_rd[t]);
      chk("wr_en", wr_en, e_wr[t]);
      if (t == 0) begin
        chk("hold_a", rd_addr_a, h_a);
        chk("hold_b", rd_addr_b, h_b);
        chk("hold_tf", tf_addr, h_tf);
      end else begin
        chk("rd_addr_a", rd_addr_a, e_a[t]);
        chk("rd_addr_b", rd_addr_b, e_b[t]);
        chk("tf_addr", tf_addr, e_tf[t]);
      end
      if (e_wr[t] != 0) begin
        chk("wr_addr_a", wr_addr_a, e_wa[t]);
        chk("wr_addr_b", wr_addr_b, e_wb[t]);
      end
      if (t >= 1 && t <= TOT) chk("stage", stage, e_st[t]);
      if (rd_en === 1'b1) nrd++;
      if (wr_en === 1'b1) nwr++;
      if (done === 1'b1) begin ndone++; dcyc = t; end
    end
    start = 1'b0;
    chk("n_rd", nrd, LOGN * N / 2);
    chk("n_wr", nwr, LOGN * N / 2);
    chk("n_done", ndone, 1);
    chk("done_cycle", dcyc, TOT);
    h_a = e_a[TOT]; h_b = e_b[TOT]; h_tf = e_tf[TOT];
  endtask

  // Start a run, abort it with reset at rst_at for rst_len cycles, then idle for gap cycles.
  task automatic run_abort(input int rst_at, input int rst_len, input int gap, output int start_abs);
    start_abs = -1;
    for (int t = 0; t < rst_at + rst_len + gap; t++) begin
      @(posedge clk); #1;
      start = (t == 0);
      if (t == rst_at) rst = 1'b0;
      if (t == rst_at + rst_len) rst = 1'b1;
      @(negedge clk);
      if (t == 0) start_abs = cyc;
      if (t < rst_at) begin
        chk("pre_rd_en", rd_en, e_rd[t]);
        chk("pre_wr_en", wr_en, e_wr[t]);
      end else if (t < rst_at + rst_len) begin
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_rd_a", rd_addr_a, 0);
        chk("rst_rd_b", rd_addr_b, 0);
        chk("rst_tf", tf_addr, 0);
        chk("rst_wr_a", wr_addr_a, 0);
        chk("rst_wr_b", wr_addr_b, 0);
        chk("rst_stage", stage, 0);
      end else begin
        chk("post_busy", busy, 0);
        chk("post_rd_en", rd_en, 0);
        chk("post_wr_en", wr_en, 0);
      end
    end
    start = 1'b0;
    h_a = 0; h_b = 0; h_tf = 0;
  endtask

  initial begin
    int s0, s1, sp;
    build_model();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_rd_en", rd_en, 0);
    chk("reset_wr_en", wr_en, 0);
    chk("reset_done", done, 0);
    chk("reset_rd_a", rd_addr_a, 0);
    chk("reset_tf", tf_addr, 0);
    chk("reset_stage", stage, 0);
    @(posedge clk); #1 rst = 1'b1;

    idle_cycles($urandom_range(1, 8));
    run_full(500, 0, s0);

    idle_cycles($urandom_range(1, 8));
    run_full($urandom_range(1, TOT - 1), $urandom_range(1, TOT - 1), s0);

    run_abort(300, 5, 5, s0);
    run_full(0, 0, s1);
    chk("abort_done_abs", last_done_cyc - s0, 310 + TOT);

    idle_cycles($urandom_range(1, 4));
    run_abort($urandom_range(2, TOT - 2), $urandom_range(1, 4), $urandom_range(1, 6), s0);
    sp = $urandom_range(1, TOT - 1);
    run_full(sp, $urandom_range(1, TOT - 1), s1);
    chk("rand_done_abs", last_done_cyc - s1, TOT);

    idle_cycles(3);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ntt_ctrl.md
NTT_CTRL -- requirements
Module: ntt_ctrl

Interface
REQ-001 SHALL have parameter LOGN, default 8, meaning log2 of the transform length (N = 256 coefficients).
REQ-002 SHALL have parameter PIPE_LAT, default 2, meaning cycles from read issue to butterfly result (1 RAM read + 1 butterfly register).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request to run one forward NTT; sampled only in IDLE.
REQ-006 busy  output  1  high while a transform is in progress.
REQ-007 done  output  1  one-cycle pulse when the transform completes.
REQ-008 rd_en  output  1  coefficient RAM read strobe, both ports.
REQ-009 rd_addr_a, rd_addr_b  output  LOGN each  butterfly X and Y read addresses.
REQ-010 tf_addr  output  LOGN  twiddle ROM address, issued in the same cycle as rd_en.
REQ-011 wr_en  output  1  write-back strobe for butterfly outputs A and B.
REQ-012 wr_addr_a, wr_addr_b  output  LOGN each  write-back addresses for A and B.
REQ-013 stage  output  3  current stage index 0..LOGN-1, for debug.

Function
REQ-014 SHALL implement the FSM states IDLE, RUN, DRAIN and DONE.
REQ-015 IDLE -> RUN when start=1; stage and butterfly counter c SHALL be cleared to 0.
REQ-016 In RUN: rd_en=1 every cycle and c increments by 1; after c=N/2-1, SHALL go to DRAIN.
REQ-017 DRAIN SHALL last exactly PIPE_LAT cycles with rd_en=0; then go to DONE if stage=LOGN-1, else stage+1, c=0 and back to RUN.
REQ-018 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-019 busy SHALL be 1 in RUN, DRAIN and DONE, and 0 in IDLE.
REQ-020 Address generation for stage s, with len = N>>(s+1):
  - group = c >> log2(len); offset = c & (len-1)
  - rd_addr_a = group*2*len + offset
  - rd_addr_b = rd_addr_a + len
  - tf_addr = (1<<s) + group
REQ-021 When rd_en=0, the rd/tf address outputs SHALL hold their last value.
REQ-022 wr_en, wr_addr_a and wr_addr_b SHALL be rd_en, rd_addr_a and rd_addr_b delayed by exactly PIPE_LAT cycles, through a valid/address shift pipeline.
REQ-023 The last write of a stage SHALL occur no later than the cycle before the first read of the next stage (no read-after-write hazard).
REQ-024 start while busy=1 SHALL be ignored; no restart and no queuing.
REQ-025 Total latency: start accepted in cycle 0; first rd_en in cycle 1; done in cycle 1 + LOGN*(N/2+PIPE_LAT) (1041 at defaults).
REQ-026 The arithmetic is address-only; the block SHALL instantiate no modular arithmetic.

Reset
REQ-027 While rst=0, SHALL be in IDLE with:
  - stage, c and the pipeline valid bits = 0
  - busy, done, rd_en, wr_en = 0
  - all address outputs = 0
REQ-028 Reset asserted mid-transform SHALL abort immediately; in-flight writes are discarded (wr_en=0), and after release the block waits in IDLE for a new start.

Verification
REQ-029 Start at defaults -> cycle 1: rd_en=1, rd_addr_a=0, rd_addr_b=128, tf_addr=1; cycle 3: wr_en=1, wr_addr_a=0, wr_addr_b=128.
REQ-030 Stage 1, c=64 -> rd_addr_a=128, rd_addr_b=192, tf_addr=3; stage 7, c=5 -> rd_addr_a=10, rd_addr_b=11, tf_addr=133.
REQ-031 Full run -> exactly 1024 rd_en cycles and 1024 wr_en cycles; each (a,b) pair appears once per stage; done=1 only in cycle 1041, then busy=0.
REQ-032 Stage boundary -> exactly PIPE_LAT cycles with rd_en=0 between stages; the last wr_en of a stage falls in the final DRAIN cycle.
REQ-033 start pulsed at cycle 500 during a run -> no effect on the address sequence; done still at cycle 1041.
REQ-034 rst=0 at cycle 300, released at 305, start at 310 -> all outputs 0 during reset; no wr_en between 300 and 310; fresh sequence from stage 0 with done at cycle 1351.
